// File: rtl/mem_write_buffer_pkg.sv
// Shared types for the ALU data-write path: the queued write entry and the
// drain state machine encoding used by mem_write_buffer.
package mem_write_buffer_pkg;

  // Default geometry of the write path (address width matches the data
  // memory, data width matches REG_WIDTH).
  localparam int MWB_ADDR_WIDTH = 16;
  localparam int MWB_DATA_WIDTH = 32;
  localparam int MWB_DEPTH      = 4;

  // One queued write, address in the upper bits so that {addr, data}
  // concatenations and this struct share the same layout.
  typedef struct packed {
    logic [MWB_ADDR_WIDTH-1:0] addr;
    logic [MWB_DATA_WIDTH-1:0] data;
  } mem_write_req_s;

  // Drain side: either nothing on the bus, or one request waiting for ack.
  typedef enum logic {
    MWB_IDLE = 1'b0,
    MWB_REQ  = 1'b1
  } mwb_state_e;

endpackage

// File: rtl/mem_write_buffer_fifo.sv
// Generic synchronous FIFO with a combinational head output and an occupancy
// count. Pushes into a full FIFO and pops from an empty one are ignored so a
// careless client cannot corrupt the pointers.
module sync_fifo #(
  parameter int width = 8,
  parameter int depth = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_ni,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic [width-1:0]        data_i,
  output logic [width-1:0]        data_o,
  output logic [$clog2(depth):0]  count_o
);

  localparam int PTR_W = $clog2(depth);
  localparam int CNT_W = $clog2(depth) + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(depth);

  logic [width-1:0] mem_q [depth];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign do_push = push_i && (count_q != FULL_COUNT);
  assign do_pop  = pop_i && (count_q != '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Storage array: plain RAM-style write, contents need no reset.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Pointers wrap naturally because depth is a power of two.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

  // Occupancy: a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      count_q <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mem_write_buffer.sv
// Write buffer between the ALU data-write port and the data-memory bus.
// Requests are queued in a sync_fifo and drained one at a time over a
// req/ack handshake; the ALU only stalls when the queue is full.
module mem_write_buffer
  import mem_write_buffer_pkg::*;
#(
  parameter int mem_addr_width = MWB_ADDR_WIDTH,
  parameter int data_width     = MWB_DATA_WIDTH,
  parameter int depth          = MWB_DEPTH
) (
  input  logic                      clk_i,
  input  logic                      reset_ni,
  input  logic                      w_valid_i,
  output logic                      w_ready_o,
  input  logic [mem_addr_width-1:0] w_addr_i,
  input  logic [data_width-1:0]     w_write_i,
  output logic                      mem_req_o,
  input  logic                      mem_ack_i,
  output logic [mem_addr_width-1:0] mem_addr_o,
  output logic [data_width-1:0]     mem_data_o,
  output logic [$clog2(depth):0]    count_o,
  output logic                      busy_o
);

  localparam int CNT_W   = $clog2(depth) + 1;
  localparam int ENTRY_W = mem_addr_width + data_width;

  mwb_state_e                state_q;
  logic                      push;
  logic                      pop;
  logic                      have_entry;
  logic [ENTRY_W-1:0]        fifo_head;
  logic [CNT_W-1:0]          fifo_count;
  logic [mem_addr_width-1:0] head_addr;
  logic [data_width-1:0]     head_data;

  // Ready looks only at the registered count, so a full queue refuses a
  // push even on the edge where the drain side pops.
  assign w_ready_o  = (fifo_count < CNT_W'(depth));
  assign push       = w_valid_i && w_ready_o;
  assign have_entry = (fifo_count != '0);
  assign head_addr  = fifo_head[ENTRY_W-1:data_width];
  assign head_data  = fifo_head[data_width-1:0];
  assign count_o    = fifo_count;
  assign busy_o     = have_entry || mem_req_o;

  // Pop whenever the bus slot becomes free (idle, or current request acked).
  always_comb begin
    pop = 1'b0;
    if (have_entry) begin
      if (state_q == MWB_IDLE) begin
        pop = 1'b1;
      end else if (mem_ack_i) begin
        pop = 1'b1;
      end
    end
  end

  sync_fifo #(
    .width (ENTRY_W),
    .depth (depth)
  ) u_fifo (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .push_i   (push),
    .pop_i    (pop),
    .data_i   ({w_addr_i, w_write_i}),
    .data_o   (fifo_head),
    .count_o  (fifo_count)
  );

  // Drain FSM with registered bus outputs; back-to-back requests on ack.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= MWB_IDLE;
      mem_req_o  <= 1'b0;
      mem_addr_o <= '0;
      mem_data_o <= '0;
    end else begin
      case (state_q)
        MWB_IDLE: begin
          if (have_entry) begin
            mem_req_o  <= 1'b1;
            mem_addr_o <= head_addr;
            mem_data_o <= head_data;
            state_q    <= MWB_REQ;
          end
        end
        MWB_REQ: begin
          if (mem_ack_i) begin
            if (have_entry) begin
              mem_addr_o <= head_addr;
              mem_data_o <= head_data;
            end else begin
              mem_req_o <= 1'b0;
              state_q   <= MWB_IDLE;
            end
          end
        end
        default: begin
          mem_req_o <= 1'b0;
          state_q   <= MWB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_write_buffer.sv
// Self-checking bench for mem_write_buffer. A queue-based reference model
// (queued entries plus one in-flight slot) predicts the bus and status
// outputs; a scoreboard of accepted writes checks every acked transfer.
module tb_mem_write_buffer;
  import mem_write_buffer_pkg::*;

  localparam int AW    = 16;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk_i     = 1'b0;
  logic          reset_ni  = 1'b0;
  logic          w_valid_i = 1'b0;
  logic          w_ready_o;
  logic [AW-1:0] w_addr_i  = '0;
  logic [DW-1:0] w_write_i = '0;
  logic          mem_req_o;
  logic          mem_ack_i = 1'b0;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_data_o;
  logic [CW-1:0] count_o;
  logic          busy_o;

  int assertions = 0;
  int failures   = 0;

  // Reference model state
  mem_write_req_s mq[$];
  mem_write_req_s sb[$];
  logic           m_infl_v = 1'b0;
  mem_write_req_s m_infl;
  logic           last_accepted;
  logic           last_acked;
  mem_write_req_s last_ack_val;
  mem_write_req_s last_exp;

  mem_write_buffer #(
    .mem_addr_width (AW),
    .data_width     (DW),
    .depth          (DEPTH)
  ) dut (
    .clk_i      (clk_i),
    .reset_ni   (reset_ni),
    .w_valid_i  (w_valid_i),
    .w_ready_o  (w_ready_o),
    .w_addr_i   (w_addr_i),
    .w_write_i  (w_write_i),
    .mem_req_o  (mem_req_o),
    .mem_ack_i  (mem_ack_i),
    .mem_addr_o (mem_addr_o),
    .mem_data_o (mem_data_o),
    .count_o    (count_o),
    .busy_o     (busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic model_reset();
    mq.delete();
    sb.delete();
    m_infl_v = 1'b0;
  endtask

  // Drive one cycle, update the model at the edge, return at edge+1.
  task automatic drive_cycle(input logic v, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input logic ack);
    mem_write_req_s ent;
    mem_write_req_s pre_val;
    w_valid_i = v;
    w_addr_i  = a;
    w_write_i = d;
    mem_ack_i = ack;
    ent.addr  = a;
    ent.data  = d;
    pre_val   = {mem_addr_o, mem_data_o};
    @(posedge clk_i);
    last_accepted = v && (mq.size() < DEPTH);
    last_acked    = m_infl_v && ack;
    last_ack_val  = pre_val;
    last_exp      = 'x;
    if (last_acked && sb.size() > 0) last_exp = sb.pop_front();
    if (!m_infl_v || ack) begin
      if (mq.size() > 0) begin
        m_infl   = mq.pop_front();
        m_infl_v = 1'b1;
      end else begin
        m_infl_v = 1'b0;
      end
    end
    if (last_accepted) begin
      mq.push_back(ent);
      sb.push_back(ent);
    end
    #1;
  endtask

  task automatic test_reset();
    reset_ni = 1'b0;
    model_reset();
    #12;
    assertions++;
    if ({mem_req_o, mem_addr_o, mem_data_o, count_o, busy_o} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: req=%0b addr=%h data=%h count=%0d busy=%0b, expected all zero",
               mem_req_o, mem_addr_o, mem_data_o, count_o, busy_o);
    end
    assertions++;
    if (w_ready_o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_ready: got %0b expected 1", w_ready_o);
    end
    @(negedge clk_i);
    reset_ni = 1'b1;
    drive_cycle(1'b1, 16'h0abc, 32'h1234_5678, 1'b0);
    assertions++;
    if (count_o !== CW'(1)) begin
      failures++;
      $display("[TB] FAIL first_push_after_release: count=%0d expected 1", count_o);
    end
    drive_cycle(1'b0, '0, '0, 1'b1);
    drive_cycle(1'b0, '0, '0, 1'b1);
    assertions++;
    if (!last_acked || last_ack_val !== last_exp || mem_req_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL first_write_drain: acked=%0b got %h expected %h req=%0b",
               last_acked, last_ack_val, last_exp, mem_req_o);
    end
  endtask

  task automatic test_single_write();
    drive_cycle(1'b1, 16'h0010, 32'hDEAD_BEEF, 1'b0);
    assertions++;
    if (mem_req_o !== 1'b0 || count_o !== CW'(1)) begin
      failures++;
      $display("[TB] FAIL single_after_push: req=%0b count=%0d expected req=0 count=1", mem_req_o, count_o);
    end
    drive_cycle(1'b0, '0, '0, 1'b0);
    assertions++;
    if ({mem_req_o, mem_addr_o, mem_data_o} !== {1'b1, 16'h0010, 32'hDEAD_BEEF}) begin
      failures++;
      $display("[TB] FAIL single_request: req=%0b addr=%h data=%h expected 1 0010 deadbeef",
               mem_req_o, mem_addr_o, mem_data_o);
    end
    drive_cycle(1'b0, '0, '0, 1'b1);
    assertions++;
    if (mem_req_o !== 1'b0 || busy_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL single_ack: req=%0b busy=%0b expected 0 0", mem_req_o, busy_o);
    end
  endtask

  task automatic test_order_stall();
    for (int i = 1; i <= 5; i++) begin
      drive_cycle(1'b1, AW'(i), $urandom, 1'b0);
      assertions++;
      if (count_o !== CW'(mq.size()) || w_ready_o !== (mq.size() < DEPTH)) begin
        failures++;
        $display("[TB] FAIL stall_fill_%0d: count=%0d ready=%0b expected %0d %0b",
                 i, count_o, w_ready_o, mq.size(), mq.size() < DEPTH);
      end
    end
    assertions++;
    if ({w_ready_o, count_o, mem_req_o, mem_addr_o} !== {1'b0, CW'(4), 1'b1, AW'(1)}) begin
      failures++;
      $display("[TB] FAIL stall_full: ready=%0b count=%0d req=%0b addr=%h expected 0 4 1 0001",
               w_ready_o, count_o, mem_req_o, mem_addr_o);
    end
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1'b1, AW'(6), $urandom, 1'b0);
      assertions++;
      if ({w_ready_o, count_o, mem_addr_o} !== {1'b0, CW'(4), AW'(1)}) begin
        failures++;
        $display("[TB] FAIL stall_hold_%0d: ready=%0b count=%0d addr=%h expected 0 4 0001",
                 i, w_ready_o, count_o, mem_addr_o);
      end
    end
    for (int i = 2; i <= 5; i++) begin
      drive_cycle(1'b0, '0, '0, 1'b1);
      assertions++;
      if (mem_req_o !== 1'b1 || mem_addr_o !== AW'(i) || last_ack_val !== last_exp) begin
        failures++;
        $display("[TB] FAIL stall_drain_%0d: req=%0b addr=%h acked=%h expected 1 %h %h",
                 i, mem_req_o, mem_addr_o, last_ack_val, i, last_exp);
      end
    end
    drive_cycle(1'b0, '0, '0, 1'b1);
    assertions++;
    if (mem_req_o !== 1'b0 || busy_o !== 1'b0 || last_ack_val.addr !== AW'(5)) begin
      failures++;
      $display("[TB] FAIL stall_last: req=%0b busy=%0b acked_addr=%h expected 0 0 0005",
               mem_req_o, busy_o, last_ack_val.addr);
    end
  endtask

  task automatic test_streaming();
    int   acks = 0;
    logic seen_req = 1'b0;
    for (int cyc = 0; cyc < 40 && acks < 20; cyc++) begin
      drive_cycle(cyc < 20, AW'($urandom), $urandom, 1'b1);
      if (last_acked) begin
        acks++;
        assertions++;
        if (last_ack_val !== last_exp) begin
          failures++;
          $display("[TB] FAIL stream_data_%0d: got %h expected %h", acks, last_ack_val, last_exp);
        end
      end
      assertions++;
      if (count_o > CW'(1) || (seen_req && acks < 20 && mem_req_o !== 1'b1)) begin
        failures++;
        $display("[TB] FAIL stream_cycle_%0d: count=%0d req=%0b expected count<=1 and no bubble",
                 cyc, count_o, mem_req_o);
      end
      if (mem_req_o === 1'b1) seen_req = 1'b1;
    end
    assertions++;
    if (acks !== 20 || mem_req_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL stream_acks: got %0d acks req=%0b expected 20 acks req=0", acks, mem_req_o);
    end
  endtask

  task automatic test_simultaneous();
    logic [DW-1:0] dv [4];
    for (int i = 0; i < 4; i++) dv[i] = $urandom;
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, AW'(16'h100 + i), dv[i], 1'b0);
    assertions++;
    if ({count_o, mem_req_o, mem_addr_o} !== {CW'(2), 1'b1, AW'(16'h100)}) begin
      failures++;
      $display("[TB] FAIL simul_setup: count=%0d req=%0b addr=%h expected 2 1 0100",
               count_o, mem_req_o, mem_addr_o);
    end
    drive_cycle(1'b1, AW'(16'h103), dv[3], 1'b1);
    assertions++;
    if ({count_o, mem_addr_o, mem_data_o} !== {CW'(2), AW'(16'h101), dv[1]} ||
        last_ack_val !== {AW'(16'h100), dv[0]}) begin
      failures++;
      $display("[TB] FAIL simul_push_pop: count=%0d addr=%h data=%h acked=%h expected 2 0101 %h",
               count_o, mem_addr_o, mem_data_o, last_ack_val, dv[1]);
    end
    for (int i = 2; i <= 4; i++) begin
      drive_cycle(1'b0, '0, '0, 1'b1);
      assertions++;
      if (i < 4 && {mem_req_o, mem_addr_o, mem_data_o} !== {1'b1, AW'(16'h100 + i), dv[i]}) begin
        failures++;
        $display("[TB] FAIL simul_order_%0d: req=%0b addr=%h data=%h expected 1 %h %h",
                 i, mem_req_o, mem_addr_o, mem_data_o, 16'h100 + i, dv[i]);
      end else if (i == 4 && mem_req_o !== 1'b0) begin
        failures++;
        $display("[TB] FAIL simul_done: req=%0b expected 0", mem_req_o);
      end
    end
  endtask

  task automatic test_pointer_wrap();
    int             pushed = 0;
    int             acked  = 0;
    int             cyc    = 0;
    logic           v;
    logic           ak;
    logic           was_req_nack;
    mem_write_req_s hold;
    while ((pushed < 3*DEPTH || m_infl_v || mq.size() > 0) && cyc < 500) begin
      v  = (pushed < 3*DEPTH) && ($urandom_range(0, 9) < 6);
      ak = 1'($urandom_range(0, 1));
      was_req_nack = mem_req_o && !ak;
      hold = {mem_addr_o, mem_data_o};
      drive_cycle(v, AW'($urandom), $urandom, ak);
      cyc++;
      if (last_accepted) pushed++;
      if (was_req_nack) begin
        assertions++;
        if ({mem_req_o, mem_addr_o, mem_data_o} !== {1'b1, hold}) begin
          failures++;
          $display("[TB] FAIL wrap_stable_%0d: req=%0b bus=%h%h expected 1 %h",
                   cyc, mem_req_o, mem_addr_o, mem_data_o, hold);
        end
      end
      assertions++;
      if ({mem_req_o, count_o, w_ready_o, busy_o} !==
          {m_infl_v, CW'(mq.size()), mq.size() < DEPTH, m_infl_v || mq.size() != 0} ||
          (m_infl_v && {mem_addr_o, mem_data_o} !== m_infl)) begin
        failures++;
        $display("[TB] FAIL wrap_model_%0d: req=%0b count=%0d ready=%0b busy=%0b bus=%h%h expected %0b %0d %h",
                 cyc, mem_req_o, count_o, w_ready_o, busy_o, mem_addr_o, mem_data_o,
                 m_infl_v, mq.size(), m_infl);
      end
      if (last_acked) begin
        acked++;
        assertions++;
        if (last_ack_val !== last_exp) begin
          failures++;
          $display("[TB] FAIL wrap_order_%0d: got %h expected %h", acked, last_ack_val, last_exp);
        end
      end
    end
    assertions++;
    if (acked !== 3*DEPTH) begin
      failures++;
      $display("[TB] FAIL wrap_total: got %0d acks expected %0d within %0d cycles", acked, 3*DEPTH, cyc);
    end
  endtask

  task automatic test_reset_mid_transfer();
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, AW'($urandom), $urandom, 1'b0);
    assertions++;
    if (count_o !== CW'(2) || mem_req_o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midreset_setup: count=%0d req=%0b expected 2 1", count_o, mem_req_o);
    end
    w_valid_i = 1'b0;
    #2;
    reset_ni = 1'b0;
    model_reset();
    #1;
    assertions++;
    if ({mem_req_o, mem_addr_o, mem_data_o, count_o, busy_o, w_ready_o} !== {1'b0, AW'(0), DW'(0), CW'(0), 1'b0, 1'b1}) begin
      failures++;
      $display("[TB] FAIL midreset_async: req=%0b addr=%h data=%h count=%0d busy=%0b ready=%0b expected zeros ready=1",
               mem_req_o, mem_addr_o, mem_data_o, count_o, busy_o, w_ready_o);
    end
    @(negedge clk_i);
    reset_ni = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b0, '0, '0, 1'($urandom_range(0, 1)));
      assertions++;
      if (mem_req_o !== 1'b0 || busy_o !== 1'b0) begin
        failures++;
        $display("[TB] FAIL midreset_after_%0d: req=%0b busy=%0b expected 0 0", i, mem_req_o, busy_o);
      end
    end
  endtask

  initial begin
    $display("[TB] starting mem_write_buffer bench");
    test_reset();
    test_single_write();
    test_order_stall();
    test_streaming();
    test_simultaneous();
    test_pointer_wrap();
    test_reset_mid_transfer();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/mem_write_buffer.md
# mem_write_buffer

Memory-side responder for the ALU data-write port. Accepts write requests (address plus data) from the ALU with a valid/ready handshake, queues them in a small FIFO, and drains them one at a time to the data-memory bus using a req/ack handshake. This lets the ALU issue `ALU_OP_MEM_WRITE` without waiting on memory latency, and the ALU stalls only when the buffer is full.

## Interface

Clocking and reset: one clock, `clk_i`. Reset is asynchronous and active-low, `reset_ni`.

Parameters:
- `mem_addr_width`, default 16: width of a memory address.
- `data_width`, default 32: width of a write word. Equal to `REG_WIDTH`.
- `depth`, default 4: FIFO entries. Power of two, minimum 2.

Ports:
- `clk_i`, in, 1: clock.
- `reset_ni`, in, 1: asynchronous active-low reset.
- `w_valid_i`, in, 1: ALU write request valid.
- `w_ready_o`, out, 1: buffer can accept a request this cycle.
- `w_addr_i`, in, `mem_addr_width`: write address.
- `w_write_i`, in, `data_width`: write data.
- `mem_req_o`, out, 1: memory write request outstanding.
- `mem_ack_i`, in, 1: memory accepted the current request.
- `mem_addr_o`, out, `mem_addr_width`: address of the current request.
- `mem_data_o`, out, `data_width`: data of the current request.
- `count_o`, out, `$clog2(depth)+1`: number of queued entries, excluding the one in flight.
- `busy_o`, out, 1: `count_o != 0 || mem_req_o`.

## Operation

- **Push:** `w_valid_i && w_ready_o` at a rising edge writes `{w_addr_i, w_write_i}` at the tail. The write pointer advances modulo `depth`.
- **Ready:** `w_ready_o = (count_o < depth)`, computed from registered count only. A full FIFO does not accept a push in the same cycle as a pop.
- **Pop:** occurs only in the drain FSM transitions listed below. The head is loaded into the `mem_addr_o`/`mem_data_o` registers and the read pointer advances modulo `depth`.
- **Count:** +1 on push only, −1 on pop only, unchanged on simultaneous push and pop. Never exceeds `depth` and never underflows.
- **Drain FSM:**
  - `IDLE` with `count_o != 0`: pop, set `mem_req_o`, go to `REQ`.
  - `IDLE` with `count_o == 0`: stay.
  - `REQ` without `mem_ack_i`: hold `mem_req_o`, `mem_addr_o` and `mem_data_o` stable.
  - `REQ` with `mem_ack_i` and `count_o != 0`: pop the next entry and stay in `REQ`, giving back-to-back requests with no idle cycle.
  - `REQ` with `mem_ack_i` and `count_o == 0`: clear `mem_req_o`, go to `IDLE`.
- `mem_ack_i` is ignored in `IDLE`.
- Ordering is strict FIFO. Writes to the same address are not merged.
- Values on `w_addr_i`/`w_write_i` are don't-care when `w_valid_i` is low.

## Timing

- **Reset** (asynchronous, `reset_ni` low): FSM goes to `IDLE`, pointers and count go to 0, `mem_req_o` = 0, `mem_addr_o` = 0, `mem_data_o` = 0, `count_o` = 0, `busy_o` = 0, `w_ready_o` = 1. Any in-flight request and all queued entries are dropped.
- **Reset release:** release is synchronous to `clk_i`. The first push is accepted at the first rising edge after release.
- **Accept-to-request latency:** a push at edge k into an empty, idle buffer gives `mem_req_o` = 1 after edge k+1, i.e. 2 cycles.
- **Ack:** sampled at a rising edge with `mem_req_o` high. On that edge the next request, if any, is presented.
- **Throughput:** one write per cycle when `mem_ack_i` is held high and the ALU pushes every cycle.
- **Full:** `w_ready_o` goes low the cycle after the push that fills the FIFO. It returns high the cycle after the next pop.

## Structure

- Shared package: the `mem_write_req_s` struct `{addr, data}` and the drain-state enum `mwb_state_e` (`MWB_IDLE`, `MWB_REQ`).
- Sub-module: `sync_fifo` (parameters `width`, `depth`; ports push, pop, data in/out, count). It is reused by later read-path blocks.
- `mem_write_buffer` contains the drain FSM and the output registers.

## Test plan

- **Reset:** assert `reset_ni` low mid-transfer with `count_o`=2 and `mem_req_o`=1 -> all outputs are 0 immediately, `w_ready_o`=1, and no request follows after release.
- **Single write:** push addr 0x0010, data 0xDEADBEEF at edge k -> `mem_req_o`=1 with those values after edge k+1. Ack it -> `mem_req_o`=0 and `busy_o`=0.
- **Ordering and stall:** with `depth`=4 and `mem_ack_i`=0, push 5 times on consecutive cycles with addr 1..5 -> `w_ready_o` drops after the 5th accepted push (1 in flight, 4 queued). The 6th request is held. Then hold `mem_ack_i`=1 -> addresses 1..5 appear in order on consecutive cycles.
- **Streaming:** `mem_ack_i`=1 constantly and one push per cycle for 20 cycles -> `count_o` never exceeds 1, no bubbles after the first request, and 20 acks are observed.
- **Simultaneous push and pop:** `count_o`=2 with push and ack on the same edge -> `count_o` stays 2 and the data order is preserved.
- **Pointer wrap:** 3×`depth` writes with random ack gaps -> a scoreboard matches every address/data pair in order. `mem_addr_o`/`mem_data_o` stay stable while `mem_req_o` is high and not acked.
